// File: rtl/hps_ioctl_bridge.sv
// Host boot-data to ioctl download bridge: unpacks 32-bit host words (MSB first)
// into 8- or 16-bit ioctl write units with byte addressing, stall and write pacing.
module hps_ioctl_bridge #(
    parameter int WIDE   = 0,
    parameter int WR_GAP = 0,
    parameter int SIZE_W = 16
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic [31:0]                    host_bootdata,
    input  logic                           host_bootdata_req,
    output logic                           host_bootdata_ack,
    input  logic                           host_bootdata_download,
    input  logic [SIZE_W-1:0]              host_bootdata_size,
    input  logic [2:0]                     host_file_type,
    output logic                           ioctl_download,
    output logic [15:0]                    ioctl_index,
    output logic                           ioctl_wr,
    output logic [26:0]                    ioctl_addr,
    output logic [((WIDE != 0) ? 15 : 7):0] ioctl_dout,
    input  logic                           ioctl_wait
);

    localparam int              DW        = (WIDE != 0) ? 16 : 8;
    localparam logic [1:0]      LAST_LANE = (WIDE != 0) ? 2'd1 : 2'd3;
    localparam logic [SIZE_W:0] CNT_STEP  = (WIDE != 0) ? (SIZE_W+1)'(2) : (SIZE_W+1)'(1);
    localparam logic [26:0]     ADDR_STEP = (WIDE != 0) ? 27'd2 : 27'd1;
    localparam logic [3:0]      GAP_LOAD  = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              dl_prev_q, dl_prev_d;
    logic              armed_q, armed_d;
    logic              ack_q, ack_d;
    logic              download_q, download_d;
    logic [26:0]       addr_q, addr_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic [15:0]       index_q, index_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        gap_q, gap_d;
    logic              gap_to_wait_q, gap_to_wait_d;

    logic              wr_now;
    logic              rise;
    logic              word_done;
    logic [SIZE_W-1:0] remaining;
    logic [SIZE_W:0]   cnt_sum;
    logic [SIZE_W-1:0] cnt_sat;

    // pad_low zeroes the low byte of a 16-bit unit that carries the last odd byte.
    function automatic logic [DW-1:0] unit_of(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic        pad_low);
        logic [15:0] u;
        if (WIDE != 0) begin
            u = lane[0] ? word[15:0] : word[31:16];
            if (pad_low) u[7:0] = 8'h00;
        end else begin
            case (lane)
                2'd0:    u = {8'h00, word[31:24]};
                2'd1:    u = {8'h00, word[23:16]};
                2'd2:    u = {8'h00, word[15:8]};
                default: u = {8'h00, word[7:0]};
            endcase
        end
        return u[DW-1:0];
    endfunction

    // A level already high when reset releases must not look like a new session,
    // so edges only count once download has been seen low after reset.
    assign rise      = armed_q && !dl_prev_q && host_bootdata_download;
    assign remaining = size_q - count_q;
    assign cnt_sum   = {1'b0, count_q} + CNT_STEP;
    assign cnt_sat   = (cnt_sum > {1'b0, size_q}) ? size_q : cnt_sum[SIZE_W-1:0];
    assign word_done = (lane_q == LAST_LANE) || (cnt_sat >= size_q);

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        dl_prev_d     = host_bootdata_download;
        armed_d       = armed_q | ~host_bootdata_download;
        ack_d         = 1'b0;
        download_d    = download_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        index_d       = index_q;
        size_d        = size_q;
        count_d       = count_q;
        word_d        = word_q;
        lane_d        = lane_q;
        gap_d         = gap_q;
        gap_to_wait_d = gap_to_wait_q;
        wr_now        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    download_d = 1'b1;
                    addr_d     = '0;
                    count_d    = '0;
                    size_d     = host_bootdata_size;
                    index_d    = {13'd0, host_file_type};
                    state_d    = S_WAIT_REQ;
                end
            end

            S_WAIT_REQ: begin
                if (!host_bootdata_download) begin
                    state_d = S_DONE;
                end else if (host_bootdata_req && !ack_q) begin
                    // The ack register blocks a second accept of the same held word.
                    ack_d = 1'b1;
                    if (count_q < size_q) begin
                        word_d  = host_bootdata;
                        lane_d  = 2'd0;
                        dout_d  = unit_of(host_bootdata, 2'd0, remaining == SIZE_W'(1));
                        state_d = S_EMIT;
                    end
                end
            end

            S_EMIT: begin
                if (!ioctl_wait) begin
                    wr_now  = 1'b1;
                    addr_d  = addr_q + ADDR_STEP;
                    count_d = cnt_sat;
                    lane_d  = lane_q + 2'd1;
                    if (!word_done) begin
                        dout_d = unit_of(word_q, lane_q + 2'd1, (size_q - cnt_sat) == SIZE_W'(1));
                    end
                    if (WR_GAP > 0) begin
                        gap_d         = GAP_LOAD;
                        gap_to_wait_d = word_done;
                        state_d       = S_GAP;
                    end else begin
                        state_d = word_done ? S_WAIT_REQ : S_EMIT;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = gap_to_wait_q ? S_WAIT_REQ : S_EMIT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            S_DONE: begin
                download_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            dl_prev_q     <= 1'b0;
            armed_q       <= 1'b0;
            ack_q         <= 1'b0;
            download_q    <= 1'b0;
            addr_q        <= '0;
            dout_q        <= '0;
            index_q       <= '0;
            size_q        <= '0;
            count_q       <= '0;
            word_q        <= '0;
            lane_q        <= '0;
            gap_q         <= '0;
            gap_to_wait_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dl_prev_q     <= dl_prev_d;
            armed_q       <= armed_d;
            ack_q         <= ack_d;
            download_q    <= download_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            index_q       <= index_d;
            size_q        <= size_d;
            count_q       <= count_d;
            word_q        <= word_d;
            lane_q        <= lane_d;
            gap_q         <= gap_d;
            gap_to_wait_q <= gap_to_wait_d;
        end
    end

    // The strobe follows ioctl_wait within the same cycle; data and address are registered.
    assign ioctl_wr          = wr_now;
    assign host_bootdata_ack = ack_q;
    assign ioctl_download    = download_q;
    assign ioctl_index       = index_q;
    assign ioctl_addr        = addr_q;
    assign ioctl_dout        = dout_q;

endmodule

// File: tb/tb_hps_ioctl_bridge.sv
// Bench for hps_ioctl_bridge: three instances (8-bit, 16-bit, 8-bit with WR_GAP=3) share
// one host driver and are compared against a byte-stream reference model.
module tb_hps_ioctl_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] host_bootdata = '0;
    logic        host_req = 1'b0;
    logic        host_dl = 1'b0;
    logic [15:0] host_size = '0;
    logic [2:0]  host_type = '0;
    logic        ioctl_wait = 1'b0;
    int          sel = 0;

    logic        dl_b, dl_w, dl_g, req_b, req_w, req_g;
    logic        ack_b, ack_w, ack_g, dlo_b, dlo_w, dlo_g, wr_b, wr_w, wr_g;
    logic [15:0] idx_b, idx_w, idx_g;
    logic [26:0] addr_b, addr_w, addr_g;
    logic [7:0]  dout_b, dout_g;
    logic [15:0] dout_w;

    logic        ack_m, dlo_m, wr_m;
    logic [15:0] idx_m, dout_m;
    logic [26:0] addr_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    assign dl_b  = host_dl  && (sel == 0);
    assign dl_w  = host_dl  && (sel == 1);
    assign dl_g  = host_dl  && (sel == 2);
    assign req_b = host_req && (sel == 0);
    assign req_w = host_req && (sel == 1);
    assign req_g = host_req && (sel == 2);

    hps_ioctl_bridge #(.WIDE(0), .WR_GAP(0), .SIZE_W(16)) u_byte (
        .clk_sys(clk_sys), .reset_n(reset_n), .host_bootdata(host_bootdata),
        .host_bootdata_req(req_b), .host_bootdata_ack(ack_b), .host_bootdata_download(dl_b),
        .host_bootdata_size(host_size), .host_file_type(host_type), .ioctl_download(dlo_b),
        .ioctl_index(idx_b), .ioctl_wr(wr_b), .ioctl_addr(addr_b), .ioctl_dout(dout_b),
        .ioctl_wait(ioctl_wait));

    hps_ioctl_bridge #(.WIDE(1), .WR_GAP(0), .SIZE_W(16)) u_wide (
        .clk_sys(clk_sys), .reset_n(reset_n), .host_bootdata(host_bootdata),
        .host_bootdata_req(req_w), .host_bootdata_ack(ack_w), .host_bootdata_download(dl_w),
        .host_bootdata_size(host_size), .host_file_type(host_type), .ioctl_download(dlo_w),
        .ioctl_index(idx_w), .ioctl_wr(wr_w), .ioctl_addr(addr_w), .ioctl_dout(dout_w),
        .ioctl_wait(ioctl_wait));

    hps_ioctl_bridge #(.WIDE(0), .WR_GAP(3), .SIZE_W(16)) u_gap (
        .clk_sys(clk_sys), .reset_n(reset_n), .host_bootdata(host_bootdata),
        .host_bootdata_req(req_g), .host_bootdata_ack(ack_g), .host_bootdata_download(dl_g),
        .host_bootdata_size(host_size), .host_file_type(host_type), .ioctl_download(dlo_g),
        .ioctl_index(idx_g), .ioctl_wr(wr_g), .ioctl_addr(addr_g), .ioctl_dout(dout_g),
        .ioctl_wait(ioctl_wait));

    always_comb begin
        case (sel)
            1: begin
                ack_m = ack_w; dlo_m = dlo_w; idx_m = idx_w;
                wr_m = wr_w; addr_m = addr_w; dout_m = dout_w;
            end
            2: begin
                ack_m = ack_g; dlo_m = dlo_g; idx_m = idx_g;
                wr_m = wr_g; addr_m = addr_g; dout_m = {8'h00, dout_g};
            end
            default: begin
                ack_m = ack_b; dlo_m = dlo_b; idx_m = idx_b;
                wr_m = wr_b; addr_m = addr_b; dout_m = {8'h00, dout_b};
            end
        endcase
    end

    // Observation: every write and ack of the selected instance, plus protocol violations.
    logic [26:0] got_addr[$];
    logic [15:0] got_data[$];
    int          wr_total = 0, ack_total = 0, cyc = 0, last_g = -1;
    int          gap_viol = 0, ack2_viol = 0, wait_viol = 0, stall_viol = 0, stall_cycles = 0;
    logic        ack_prev = 1'b0;
    logic [26:0] stall_addr = '0;
    logic [15:0] stall_dout = '0;

    // Stall control: a 10-cycle ioctl_wait window right after the second write of a session.
    int sess_id = 0, stall_sess = -1, stall_base = 0, rand_wait = 0;
    int fired = 0, stall_left = 0;

    always @(negedge clk_sys) begin
        cyc++;
        if (wr_m) begin
            got_addr.push_back(addr_m);
            got_data.push_back(dout_m);
            wr_total++;
            if (sel == 2) begin
                if (last_g >= 0 && (cyc - last_g - 1) < 3) gap_viol++;
                last_g = cyc;
            end
        end
        if (ack_m) begin
            ack_total++;
            if (ack_prev) ack2_viol++;
        end
        ack_prev = ack_m;
        if (ioctl_wait && wr_m) wait_viol++;
        if (stall_left > 0) begin
            stall_cycles++;
            if (stall_left == 10) begin
                stall_addr = addr_m;
                stall_dout = dout_m;
            end else if (addr_m != stall_addr || dout_m != stall_dout) begin
                stall_viol++;
            end
        end
    end

    always @(posedge clk_sys) begin
        #1;
        if (stall_left > 0) begin
            stall_left--;
        end else if (stall_sess == sess_id && wr_total == stall_base + 2 && fired != sess_id) begin
            fired      = sess_id;
            stall_left = 10;
        end
        ioctl_wait = (stall_left > 0) || (rand_wait != 0 && $urandom_range(0, 3) == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_session(input int s, input int size, input int ftype,
                               input logic [31:0] words[$], input bit stall);
        int          base_w, base_a, base_sc, total, n_cmp, step;
        bit          seen;
        logic [31:0] w;
        logic [7:0]  stream[$];
        int          exp_a[$];
        logic [15:0] exp_d[$];

        @(posedge clk_sys); #1;
        sel = s;
        sess_id++;
        base_w  = wr_total;
        base_a  = ack_total;
        base_sc = stall_cycles;
        stall_base = wr_total;
        if (stall) stall_sess = sess_id;
        host_size = 16'(size);
        host_type = 3'(ftype);
        host_dl   = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys); #1;
            seen = dlo_m;
        end
        check("download_rise", 32'(seen), 32'd1);
        host_size = 16'($urandom);
        host_type = 3'($urandom);
        check("index_latched", 32'(idx_m), 32'(ftype));

        foreach (words[k]) begin
            @(posedge clk_sys); #1;
            host_bootdata = words[k];
            host_req      = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk_sys); #1;
                seen = ack_m;
            end
            check("ack_seen", 32'(seen), 32'd1);
            @(posedge clk_sys); #1;
            host_req = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk_sys);
        end

        #1 host_dl = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_sys); #1;
            seen = !dlo_m;
        end
        check("download_fall", 32'(seen), 32'd1);
        repeat (3) @(posedge clk_sys);

        // Reference: the payload is the MSB-first byte stream truncated to size.
        total = size;
        if (total > 4 * words.size()) total = 4 * words.size();
        for (int i = 0; i < total; i++) begin
            w = words[i / 4];
            stream.push_back(8'(w >> (8 * (3 - (i % 4)))));
        end
        step = (s == 1) ? 2 : 1;
        for (int i = 0; i < total; i += step) begin
            exp_a.push_back(i);
            if (s == 1) exp_d.push_back({stream[i], (i + 1 < total) ? stream[i + 1] : 8'h00});
            else        exp_d.push_back({8'h00, stream[i]});
        end

        check("write_count", 32'(wr_total - base_w), 32'(exp_a.size()));
        n_cmp = wr_total - base_w;
        if (n_cmp > exp_a.size()) n_cmp = exp_a.size();
        for (int k = 0; k < n_cmp; k++) begin
            check("write_addr", 32'(got_addr[base_w + k]), 32'(exp_a[k]));
            check("write_data", 32'(got_data[base_w + k]), 32'(exp_d[k]));
        end
        check("ack_count", 32'(ack_total - base_a), 32'(words.size()));
        check("addr_end", 32'(addr_m), 32'(exp_a.size() * step));
        check("ack_back_to_back", 32'(ack2_viol), 32'd0);
        check("wr_during_wait", 32'(wait_viol), 32'd0);
        if (s == 2) check("gap_too_short", 32'(gap_viol), 32'd0);
        if (stall) begin
            check("stall_cycles", 32'(stall_cycles - base_sc), 32'd10);
            check("stall_stable", 32'(stall_viol), 32'd0);
            check("stall_addr", 32'(stall_addr), 32'd2);
            check("stall_dout", 32'(stall_dout), {24'd0, stream[2]});
        end
    endtask

    initial begin
        logic [31:0] wq[$];
        int          base_w, base_a, sz, nw;
        bit          seen;

        #3;
        check("rst_ack", 32'(ack_m), 32'd0);
        check("rst_download", 32'(dlo_m), 32'd0);
        check("rst_wr", 32'(wr_m), 32'd0);
        check("rst_addr", 32'(addr_m), 32'd0);
        check("rst_dout", 32'(dout_m), 32'd0);
        check("rst_index", 32'(idx_m), 32'd0);
        check("rst_wide_dout", 32'(dout_w), 32'd0);
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        check("idle_download", 32'(dlo_m), 32'd0);

        wq = '{32'h11223344, 32'h55667788};
        run_session(0, 6, 3, wq, 1'b0);
        wq = '{32'hAABBCCDD, 32'hEEFF0011};
        run_session(1, 5, 5, wq, 1'b0);
        wq = '{$urandom, $urandom};
        run_session(0, 8, 1, wq, 1'b1);
        wq = '{$urandom, $urandom, $urandom};
        run_session(2, 10, 6, wq, 1'b0);
        wq = '{$urandom, $urandom};
        run_session(0, 0, 2, wq, 1'b0);

        for (int r = 0; r < 8; r++) begin
            sz = $urandom_range(0, 20);
            nw = (sz + 3) / 4 + $urandom_range(0, 1);
            wq.delete();
            for (int k = 0; k < nw; k++) wq.push_back($urandom);
            rand_wait = $urandom_range(0, 1);
            run_session($urandom_range(0, 2), sz, $urandom_range(0, 7), wq, 1'b0);
        end
        rand_wait = 0;

        // Reset in the middle of a session, download level held high across it.
        @(posedge clk_sys); #1;
        sel = 0;
        sess_id++;
        base_w = wr_total;
        host_size = 16'd8;
        host_dl   = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 host_bootdata = 32'hC0FFEE42;
        host_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_sys); #1;
            seen = (wr_total == base_w + 2);
        end
        check("two_writes_before_reset", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_wr", 32'(wr_m), 32'd0);
        check("abort_download", 32'(dlo_m), 32'd0);
        check("abort_addr", 32'(addr_m), 32'd0);
        check("abort_dout", 32'(dout_m), 32'd0);
        check("abort_ack", 32'(ack_m), 32'd0);
        check("abort_index", 32'(idx_m), 32'd0);
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        base_a = ack_total;
        repeat (20) @(posedge clk_sys);
        check("no_write_after_reset", 32'(wr_total - base_w), 32'd2);
        check("no_ack_after_reset", 32'(ack_total - base_a), 32'd0);
        check("no_session_after_reset", 32'(dlo_m), 32'd0);
        #1 host_req = 1'b0;
        host_dl = 1'b0;
        repeat (3) @(posedge clk_sys);

        wq = '{32'h01020304};
        run_session(0, 4, 7, wq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
